regfile_dump_unit: RTL and testbench

//  Sequential reader for the 16x16 register file and 3-bit flag register.
//  - On start, walks one read port over R0..R(NUM_REGS-1), then one flag word.
//  - Streams each word out on a valid/ready interface.
//  - Used for debug/trace dumps and end-of-test state checks.
//  - Owns one SrcReg read port while busy; never writes the register file.

---
 rtl/regfile_dump_unit.sv | 124 ++++++++++++
 tb/tb_regfile_dump_unit.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_unit.sv
// Sequential dump of the register file (R0..R(NumRegs-1)) plus an optional flag word,
// streamed out one beat at a time on a valid/ready interface.
module regfile_dump_unit #(
   parameter int unsigned NumRegs      = 16,
   parameter int unsigned DataW        = 16,
   parameter bit          IncludeFlags = 1'b1
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        start_i,
   input  logic                        abort_i,
   output logic [$clog2(NumRegs)-1:0]  rd_reg_o,
   input  logic [DataW-1:0]            rd_data_i,
   input  logic                        z_flag_i,
   input  logic                        o_flag_i,
   input  logic                        n_flag_i,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [DataW-1:0]            out_data_o,
   output logic [$clog2(NumRegs):0]    out_idx_o,
   output logic                        out_last_o,
   output logic                        busy_o,
   output logic                        done_o
);

   localparam int unsigned IdxW    = $clog2(NumRegs);
   localparam int unsigned LastInt = IncludeFlags ? NumRegs : NumRegs - 1;
   localparam logic [IdxW:0] FlagIdx = NumRegs[IdxW:0];
   localparam logic [IdxW:0] LastIdx = LastInt[IdxW:0];
   localparam logic [IdxW:0] IdxOne  = {{IdxW{1'b0}}, 1'b1};

   typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

   state_e            state_q, state_d;
   logic [IdxW:0]     idx_q, idx_d;
   logic [IdxW-1:0]   rd_reg_q, rd_reg_d;
   logic              valid_q, valid_d;
   logic [DataW-1:0]  data_q, data_d;
   logic [IdxW:0]     oidx_q, oidx_d;
   logic              last_q, last_d;
   logic [DataW-1:0]  flag_word;

   assign flag_word = {{(DataW-3){1'b0}}, z_flag_i, o_flag_i, n_flag_i};

   // Next-state logic: abort overrides every non-idle state.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      rd_reg_d = rd_reg_q;
      valid_d  = valid_q;
      data_d   = data_q;
      oidx_d   = oidx_q;
      last_d   = last_q;
      if (abort_i && (state_q != StIdle)) begin
         state_d = StIdle;
         idx_d   = '0;
         valid_d = 1'b0;
         last_d  = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i && !abort_i) begin
                  state_d  = StRead;
                  idx_d    = '0;
                  rd_reg_d = '0;
               end
            end
            StRead: begin
               // Read port is combinational: rd_reg_q already addresses idx_q here.
               data_d  = (idx_q == FlagIdx) ? flag_word : rd_data_i;
               oidx_d  = idx_q;
               valid_d = 1'b1;
               last_d  = (idx_q == LastIdx);
               state_d = StSend;
            end
            StSend: begin
               if (out_ready_i) begin
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  if (last_q) begin
                     state_d = StDone;
                  end else begin
                     idx_d    = idx_q + IdxOne;
                     rd_reg_d = idx_d[IdxW-1:0];
                     state_d  = StRead;
                  end
               end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         rd_reg_q <= '0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         oidx_q   <= '0;
         last_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         rd_reg_q <= rd_reg_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         oidx_q   <= oidx_d;
         last_q   <= last_d;
      end
   end

   assign rd_reg_o    = rd_reg_q;
   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;
   assign out_idx_o   = oidx_q;
   assign out_last_o  = last_q;
   assign busy_o      = (state_q != StIdle);
   assign done_o      = (state_q == StDone);

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Directed bench for regfile_dump_unit: one instance with the flag word, one without.
module tb_regfile_dump_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [15:0] rf [16];
   logic        z_f, o_f, n_f;

   logic        start_a, abort_a, ready_a, valid_a, last_a, busy_a, done_a;
   logic [3:0]  rd_reg_a;
   logic [15:0] rd_data_a, data_a;
   logic [4:0]  idx_a;

   logic        start_b, abort_b, ready_b, valid_b, last_b, busy_b, done_b;
   logic [3:0]  rd_reg_b;
   logic [15:0] rd_data_b, data_b;
   logic [4:0]  idx_b;

   assign rd_data_a = rf[rd_reg_a];
   assign rd_data_b = rf[rd_reg_b];

   regfile_dump_unit #(.NumRegs(16), .DataW(16), .IncludeFlags(1'b1)) u_dut_a (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .abort_i(abort_a),
      .rd_reg_o(rd_reg_a), .rd_data_i(rd_data_a),
      .z_flag_i(z_f), .o_flag_i(o_f), .n_flag_i(n_f),
      .out_valid_o(valid_a), .out_ready_i(ready_a), .out_data_o(data_a),
      .out_idx_o(idx_a), .out_last_o(last_a), .busy_o(busy_a), .done_o(done_a)
   );

   regfile_dump_unit #(.NumRegs(16), .DataW(16), .IncludeFlags(1'b0)) u_dut_b (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .abort_i(abort_b),
      .rd_reg_o(rd_reg_b), .rd_data_i(rd_data_b),
      .z_flag_i(z_f), .o_flag_i(o_f), .n_flag_i(n_f),
      .out_valid_o(valid_b), .out_ready_i(ready_b), .out_data_o(data_b),
      .out_idx_o(idx_b), .out_last_o(last_b), .busy_o(busy_b), .done_o(done_b)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Beat capture and stall stability checks, sampled mid-cycle.
   logic [15:0] qd_a [$];
   logic [4:0]  qi_a [$];
   logic        ql_a [$];
   logic [15:0] qd_b [$];
   logic [4:0]  qi_b [$];
   logic        ql_b [$];
   int          done_cnt_a = 0;
   logic        stall_a = 1'b0;
   logic [15:0] sd_a;
   logic [4:0]  si_a;

   always @(negedge clk) begin
      if (stall_a) begin
         check_val("stall_valid_held", {31'd0, valid_a}, 32'd1);
         if (valid_a) begin
            check_val("stall_data", {16'd0, data_a}, {16'd0, sd_a});
            check_val("stall_idx", {27'd0, idx_a}, {27'd0, si_a});
         end
      end
      stall_a = valid_a && !ready_a && !abort_a && rst_n;
      sd_a    = data_a;
      si_a    = idx_a;
      if (valid_a && ready_a) begin
         qd_a.push_back(data_a);
         qi_a.push_back(idx_a);
         ql_a.push_back(last_a);
      end
      if (done_a) done_cnt_a++;
      if (valid_b && ready_b) begin
         qd_b.push_back(data_b);
         qi_b.push_back(idx_b);
         ql_b.push_back(last_b);
      end
   end

   function automatic logic [15:0] exp_data(input int i);
      if (i < 16) return 16'hA000 + 16'(i);
      return 16'h0005;
   endfunction

   task automatic clear_a();
      qd_a.delete();
      qi_a.delete();
      ql_a.delete();
   endtask

   task automatic check_dump_a(input string tag);
      int n;
      check_val({tag, "_beats"}, qd_a.size(), 32'd17);
      n = (qd_a.size() < 17) ? qd_a.size() : 17;
      for (int i = 0; i < n; i++) begin
         check_val({tag, "_idx"}, {27'd0, qi_a[i]}, i);
         check_val({tag, "_data"}, {16'd0, qd_a[i]}, {16'd0, exp_data(i)});
         check_val({tag, "_last"}, {31'd0, ql_a[i]}, {31'd0, (i == 16)});
      end
   endtask

   task automatic wait_done_a(input int max, output int n);
      n = 0;
      while (!done_a && n < max) begin
         tick();
         n++;
      end
      check_val("done_seen_a", {31'd0, done_a}, 32'd1);
   endtask

   task automatic wait_beat_a(input logic [4:0] idx);
      int n;
      n = 0;
      while (!(valid_a && idx_a == idx) && n < 100) begin
         tick();
         n++;
      end
      check_val("beat_found", {31'd0, valid_a}, 32'd1);
   endtask

   logic [7:0] lfsr = 8'hA5;
   int         n, d0;

   initial begin
      rst_n = 1'b0;
      start_a = 0; abort_a = 0; ready_a = 0;
      start_b = 0; abort_b = 0; ready_b = 0;
      z_f = 1'b1; o_f = 1'b0; n_f = 1'b1;
      for (int k = 0; k < 16; k++) rf[k] = 16'hA000 + 16'(k);
      #2;
      check_val("rst_valid", {31'd0, valid_a}, 0);
      check_val("rst_busy", {31'd0, busy_a}, 0);
      check_val("rst_done", {31'd0, done_a}, 0);
      check_val("rst_data", {16'd0, data_a}, 0);
      check_val("rst_idx", {27'd0, idx_a}, 0);
      check_val("rst_rd_reg", {28'd0, rd_reg_a}, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // 1: full dump with ready held high, exact timing.
      ready_a = 1'b1;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      check_val("t1_busy_read", {31'd0, busy_a}, 1);
      check_val("t1_valid_read", {31'd0, valid_a}, 0);
      tick();
      check_val("t1_first_valid", {31'd0, valid_a}, 1);
      check_val("t1_first_data", {16'd0, data_a}, 32'hA000);
      n = 2;
      while (!done_a && n < 100) begin
         tick();
         n++;
      end
      check_val("t1_done", {31'd0, done_a}, 1);
      check_val("t1_start_to_done", n, 35);
      tick();
      check_val("t1_done_pulse", {31'd0, done_a}, 0);
      check_val("t1_idle", {31'd0, busy_a}, 0);
      check_dump_a("t1");
      check_val("t1_done_cnt", done_cnt_a, 1);

      // 2: LFSR-driven backpressure.
      clear_a();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      n = 0;
      while (!done_a && n < 400) begin
         lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         ready_a = lfsr[0];
         tick();
         n++;
      end
      check_val("t2_done", {31'd0, done_a}, 1);
      ready_a = 1'b1;
      tick();
      check_dump_a("t2");

      // 3: no flag word.
      ready_b = 1'b1;
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      n = 0;
      while (!done_b && n < 100) begin
         tick();
         n++;
      end
      check_val("t3_done", {31'd0, done_b}, 1);
      check_val("t3_beats", qd_b.size(), 16);
      for (int i = 0; i < qd_b.size() && i < 16; i++) begin
         check_val("t3_idx", {27'd0, qi_b[i]}, i);
         check_val("t3_data", {16'd0, qd_b[i]}, {16'd0, exp_data(i)});
         check_val("t3_last", {31'd0, ql_b[i]}, {31'd0, (i == 15)});
      end
      tick();

      // 4: abort while stalled on beat 7.
      clear_a();
      d0 = done_cnt_a;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_beat_a(5'd7);
      ready_a = 1'b0;
      abort_a = 1'b1;
      tick();
      abort_a = 1'b0;
      check_val("t4_valid", {31'd0, valid_a}, 0);
      check_val("t4_busy", {31'd0, busy_a}, 0);
      check_val("t4_last", {31'd0, last_a}, 0);
      repeat (3) tick();
      check_val("t4_no_done", done_cnt_a, d0);
      check_val("t4_beats_before", qd_a.size(), 7);
      clear_a();
      ready_a = 1'b1;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_done_a(100, n);
      tick();
      check_dump_a("t4_restart");

      // 5: start pulsed mid-dump is ignored.
      clear_a();
      d0 = done_cnt_a;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_beat_a(5'd3);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_done_a(100, n);
      repeat (5) tick();
      check_val("t5_idle", {31'd0, busy_a}, 0);
      check_val("t5_done_cnt", done_cnt_a, d0 + 1);
      check_dump_a("t5");

      // 6: async reset between edges.
      clear_a();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      repeat (10) tick();
      #2 rst_n = 1'b0;
      #1;
      check_val("t6_valid", {31'd0, valid_a}, 0);
      check_val("t6_busy", {31'd0, busy_a}, 0);
      check_val("t6_data", {16'd0, data_a}, 0);
      check_val("t6_idx", {27'd0, idx_a}, 0);
      check_val("t6_rd_reg", {28'd0, rd_reg_a}, 0);
      check_val("t6_last", {31'd0, last_a}, 0);
      check_val("t6_done", {31'd0, done_a}, 0);
      rst_n = 1'b1;
      repeat (2) tick();
      clear_a();
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_done_a(100, n);
      tick();
      check_dump_a("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
